// File: rtl/ksa.sv
// ARC4 key-scheduling stage: permutes the shared S memory in place using the key.
// Define KSA_FAST_EQ_EN to skip the read/swap of iterations where j equals i.
module ksa #(
   parameter int KEY_BYTES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   output logic                   rdy,
   input  logic [KEY_BYTES*8-1:0] key,
   output logic [7:0]             addr,
   input  logic [7:0]             rddata,
   output logic [7:0]             wrdata,
   output logic                   wren
);

   localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_I,
      S_GET_I,
      S_RD_J,
      S_GET_J,
      S_WR_I,
      S_WR_J
   } state_t;

   state_t                 r_state;
   logic [7:0]             r_i;
   logic [7:0]             r_j;
   logic [KW-1:0]          r_kidx;
   logic [7:0]             r_si;
   logic [7:0]             r_sj;
   logic [KEY_BYTES*8-1:0] r_key;

   logic [7:0]    w_kbyte;
   logic [7:0]    w_jnew;
   logic [KW-1:0] w_kidx_nxt;
   logic          w_last;

   // byte 0 is the most significant byte of the key
   always_comb begin
      w_kbyte = '0;
      for (int b = 0; b < KEY_BYTES; b++) begin
         if (r_kidx == KW'(b)) w_kbyte = r_key[8*(KEY_BYTES-1-b) +: 8];
      end
   end

   assign w_jnew     = r_j + rddata + w_kbyte;
   assign w_last     = (r_i == 8'hFF);
   assign w_kidx_nxt = (r_kidx == KW'(KEY_BYTES-1)) ? '0 : r_kidx + KW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_i     <= '0;
         r_j     <= '0;
         r_kidx  <= '0;
         r_si    <= '0;
         r_sj    <= '0;
         r_key   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (en) begin
                  r_key   <= key;
                  r_i     <= '0;
                  r_j     <= '0;
                  r_kidx  <= '0;
                  r_state <= S_RD_I;
               end
            end
            S_RD_I: r_state <= S_GET_I;
            S_GET_I: begin
               r_si <= rddata;
               r_j  <= w_jnew;
`ifdef KSA_FAST_EQ_EN
               if (w_jnew == r_i) begin
                  if (w_last) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_i     <= r_i + 8'd1;
                     r_kidx  <= w_kidx_nxt;
                     r_state <= S_RD_I;
                  end
               end else begin
                  r_state <= S_RD_J;
               end
`else
               r_state <= S_RD_J;
`endif
            end
            S_RD_J: r_state <= S_GET_J;
            S_GET_J: begin
               r_sj    <= rddata;
               r_state <= S_WR_I;
            end
            S_WR_I: r_state <= S_WR_J;
            S_WR_J: begin
               if (w_last) begin
                  r_state <= S_IDLE;
               end else begin
                  r_i     <= r_i + 8'd1;
                  r_kidx  <= w_kidx_nxt;
                  r_state <= S_RD_I;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      rdy    = 1'b0;
      wren   = 1'b0;
      addr   = r_i;
      wrdata = 8'h00;
      unique case (r_state)
         S_IDLE: rdy = 1'b1;
         S_RD_J, S_GET_J: addr = r_j;
         S_WR_I: begin
            wrdata = r_sj;
            wren   = 1'b1;
         end
         S_WR_J: begin
            addr   = r_j;
            wrdata = r_si;
            wren   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ksa.sv
// Randomised scoreboard bench for ksa: expected S writes are queued per run
// and a monitor compares every DUT write; latency and final S are also checked.
module tb_ksa;

   localparam int KB = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic            rdy;
   logic [KB*8-1:0] key;
   logic [7:0]      addr;
   logic [7:0]      rddata;
   logic [7:0]      wrdata;
   logic            wren;
   logic            init_req;

   logic [7:0]  mem   [256];
   logic [7:0]  ref_s [256];
   logic [15:0] exp_q [$];
   int          exp_lat;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   ksa #(.KEY_BYTES(KB)) dut (
      .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
      .addr(addr), .rddata(rddata), .wrdata(wrdata), .wren(wren)
   );

   // single-port synchronous S memory
   always @(posedge clk) begin
      if (init_req) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
      end else begin
         if (wren) mem[addr] <= wrdata;
         rddata <= mem[addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h need %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (wren === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h need none",
                     addr, wrdata);
         end else begin
            chk("write", {16'h0, addr, wrdata}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   // Reference KSA on ref_s: queues the expected write sequence and latency.
   function automatic void model(input logic [KB*8-1:0] k);
      int  j = 0;
      int  lat = 0;
      int  kb;
      logic [7:0] t;
      bit  fast = 1'b0;
`ifdef KSA_FAST_EQ_EN
      fast = 1'b1;
`endif
      for (int i = 0; i < 256; i++) begin
         kb = int'((k >> (8 * (KB - 1 - (i % KB)))) & 24'hFF);
         j  = (j + int'(ref_s[i]) + kb) % 256;
         if (fast && j == i) begin
            lat += 2;
         end else begin
            exp_q.push_back({8'(i), ref_s[j]});
            exp_q.push_back({8'(j), ref_s[i]});
            t        = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
            lat += 6;
         end
      end
      exp_lat = lat;
   endfunction

   task automatic init_s();
      @(negedge clk);
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
   endtask

   task automatic wait_done(input int start_cnt, input bit toggle);
      int cnt = start_cnt;
      int bad = 0;
      repeat (4000) begin
         @(negedge clk);
         if (rdy) break;
         cnt++;
         if (toggle) en = (cnt < 200) ? cnt[0] : 1'b0;
      end
      chk("latency", cnt, exp_lat);
      chk("queue_drained", exp_q.size(), 0);
      for (int k = 0; k < 256; k++) if (mem[k] !== ref_s[k]) bad++;
      chk("final_S", bad, 0);
   endtask

   task automatic start(input logic [KB*8-1:0] k, input bit hold);
      @(negedge clk);
      chk("rdy_before_start", {31'h0, rdy}, 1);
      model(k);
      key = k;
      en  = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) en = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      key      = '0;
      init_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_rdy", {31'h0, rdy}, 1);
      chk("reset_wren", {31'h0, wren}, 0);
      chk("reset_addr", {24'h0, addr}, 0);
      chk("reset_wrdata", {24'h0, wrdata}, 0);

      init_s();
      start(24'h000000, 1'b0);
      wait_done(0, 1'b0);

      init_s();
      start(24'h1E4600, 1'b0);
      wait_done(0, 1'b0);

      init_s();
      start(24'($urandom), 1'b0);
      wait_done(0, 1'b0);
      // continue from the already-permuted S
      start(24'($urandom), 1'b0);
      wait_done(0, 1'b0);

      init_s();
      start(24'($urandom), 1'b0);
      wait_done(0, 1'b1);

      init_s();
      start(24'hA5C317, 1'b1);
      wait_done(0, 1'b0);
      model(24'hA5C317);
      @(negedge clk);
      chk("restart_while_held", {31'h0, rdy}, 0);
      en = 1'b0;
      wait_done(1, 1'b0);

      init_s();
      start(24'($urandom), 1'b0);
      repeat (99) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_rdy", {31'h0, rdy}, 1);
      chk("midrst_wren", {31'h0, wren}, 0);
      chk("midrst_addr", {24'h0, addr}, 0);
      exp_q.delete();
      init_s();
      start(24'($urandom), 1'b0);
      wait_done(0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
